rtc_bus_arbiter: RTL

Scheduler for the shared multiplexed AD/CS/WR/RD bus to the RTC chip. It issues periodic and on-demand read transactions and user write transactions, one at a time, by enabling the read or write sequencer and steering the external AD-bus mux. It holds each grant until the owning sequencer reports completion, then forces an idle turnaround gap before the next grant. It sits between the user-programming FSM and display-refresh logic on one side and the read/write timing sequencers on the other.

---
 rtl/rtc_bus_arbiter_if.sv | 25 ++
 rtl/rtc_bus_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/rtc_bus_arbiter_if.sv
// Bundle of request/done inputs and grant/status outputs between the RTC bus arbiter
// and its clients (user FSM, display refresh, read/write sequencers).
interface rtc_bus_arbiter_if;
  logic       wr_req;
  logic       rd_req;
  logic       rd_done;
  logic       wr_done;
  logic       en_rd;
  logic       en_wr;
  logic [1:0] bus_sel;
  logic       wr_ack;
  logic       rd_valid;
  logic       busy;
  logic       timeout_err;

  modport master (
    input  wr_req, rd_req, rd_done, wr_done,
    output en_rd, en_wr, bus_sel, wr_ack, rd_valid, busy, timeout_err
  );

  modport slave (
    output wr_req, rd_req, rd_done, wr_done,
    input  en_rd, en_wr, bus_sel, wr_ack, rd_valid, busy, timeout_err
  );
endinterface

// File: rtl/rtc_bus_arbiter.sv
// Arbiter for the shared RTC AD/CS/WR/RD bus: periodic/on-demand reads, user writes, turnaround gap.
// Optional per-grant watchdog enabled by defining RTC_ARB_TIMEOUT_EN.
module rtc_bus_arbiter #(
  parameter int unsigned READ_PERIOD = 1000,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input logic               clk,
  input logic               reset,
  rtc_bus_arbiter_if.master bus
);

  localparam int unsigned TW = $clog2(READ_PERIOD);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  if (READ_PERIOD < 2 || GAP_CYCLES < 1 || TIMEOUT < 2) begin : g_param_check
    $error("rtc_bus_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {StIdle, StGntRd, StGntWr, StGap} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q;
  logic [GW-1:0] gap_cnt_q;
  logic          rd_pend_q, rd_pend_d;
  logic          last_wr_q;
  logic          timer_tc, rd_pend_eff, rd_fin, wr_fin, gap_done, to_hit;
  logic          en_rd_q, en_wr_q, wr_ack_q, rd_valid_q, busy_q;
  logic          en_rd_d, en_wr_d, wr_ack_d, rd_valid_d, busy_d;
  logic [1:0]    bus_sel_q, bus_sel_d;

  assign timer_tc    = (timer_q == TW'(READ_PERIOD - 1));
  // A same-cycle timer wrap or rd_req counts as pending so arbitration reacts without delay.
  assign rd_pend_eff = rd_pend_q | bus.rd_req | timer_tc;
  assign rd_fin      = (state_q == StGntRd) && bus.rd_done;
  assign wr_fin      = (state_q == StGntWr) && bus.wr_done;
  assign gap_done    = (gap_cnt_q == GW'(GAP_CYCLES - 1));

`ifdef RTC_ARB_TIMEOUT_EN
  localparam int unsigned TOW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TOW-1:0] to_cnt_q;
  logic           timeout_err_q;
  logic           in_grant;

  assign in_grant = (state_q == StGntRd) || (state_q == StGntWr);
  assign to_hit   = in_grant && (to_cnt_q == TOW'(TIMEOUT - 1)) && !rd_fin && !wr_fin;

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      to_cnt_q <= (in_grant && state_d == state_q) ? to_cnt_q + 1'b1 : '0;
      if (to_hit) timeout_err_q <= 1'b1;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  assign to_hit          = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      gap_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      last_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_tc ? '0 : timer_q + 1'b1;
      gap_cnt_q <= (state_q == StGap && state_d == StGap) ? gap_cnt_q + 1'b1 : '0;
      rd_pend_q <= rd_pend_d;
      if (wr_fin)      last_wr_q <= 1'b1;
      else if (rd_fin) last_wr_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.wr_req && rd_pend_eff) state_d = last_wr_q ? StGntRd : StGntWr;
        else if (bus.wr_req)           state_d = StGntWr;
        else if (rd_pend_eff)          state_d = StGntRd;
      end
      StGntRd: if (rd_fin || to_hit) state_d = StGap;
      StGntWr: if (wr_fin || to_hit) state_d = StGap;
      StGap:   if (gap_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_pend_d  = (state_q == StIdle && state_d == StGntRd) ? 1'b0 : rd_pend_eff;
    en_rd_d    = (state_d == StGntRd);
    en_wr_d    = (state_d == StGntWr);
    bus_sel_d  = {en_wr_d, en_rd_d};
    wr_ack_d   = wr_fin;
    rd_valid_d = rd_fin;
    busy_d     = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_rd_q    <= 1'b0;
      en_wr_q    <= 1'b0;
      bus_sel_q  <= 2'b00;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      en_rd_q    <= en_rd_d;
      en_wr_q    <= en_wr_d;
      bus_sel_q  <= bus_sel_d;
      wr_ack_q   <= wr_ack_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.en_rd    = en_rd_q;
  assign bus.en_wr    = en_wr_q;
  assign bus.bus_sel  = bus_sel_q;
  assign bus.wr_ack   = wr_ack_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy_q;

endmodule
